// File: rtl/nikon_enc_emu.sv
// Encoder-side responder for the half-duplex serial position link: receives a
// read command, then answers with a 5-byte CRC-8 protected position frame.
module nikon_enc_emu #(
  parameter int         CLKS_PER_BIT = 20,
  parameter int         TURN_CLKS    = 40,
  parameter logic [7:0] CMD_READ     = 8'h1A
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iEn,
  input  logic        iRx,
  input  logic [19:0] iPos_st,
  input  logic        iWarning,
  output logic        oTx,
  output logic        oDir,
  output logic        oBusy,
  output logic        oCmd_err,
  output logic        oFrame_done
);

  localparam int MAXC = (TURN_CLKS > CLKS_PER_BIT) ? TURN_CLKS : CLKS_PER_BIT;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CLKS - 1);

  typedef enum logic [2:0] {IDLE, RX, TURN, PRE, TX} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    bit_reg, bit_next;
  logic [2:0]    byte_reg, byte_next;
  logic [7:0]    shift_reg, shift_next;
  logic [19:0]   pos_reg, pos_next;
  logic          warn_reg, warn_next;
  logic [7:0]    crc_reg, crc_next;
  logic          tx_reg, tx_next;
  logic          dir_reg, dir_next;
  logic          busy_reg, busy_next;
  logic          err_reg, err_next;
  logic          done_reg, done_next;
  logic          rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic [7:0]    crc_calc;
  logic [7:0]    cur_byte;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  assign crc_calc = crc8_byte(crc8_byte(crc8_byte(crc8_byte(8'h00, CMD_READ),
                    pos_reg[7:0]), pos_reg[15:8]), {warn_reg, 3'b000, pos_reg[19:16]});

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      byte_reg    <= '0;
      shift_reg   <= '0;
      pos_reg     <= '0;
      warn_reg    <= 1'b0;
      crc_reg     <= '0;
      tx_reg      <= 1'b1;
      dir_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      err_reg     <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      rx_meta_reg <= iRx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_reg     <= bit_next;
      byte_reg    <= byte_next;
      shift_reg   <= shift_next;
      pos_reg     <= pos_next;
      warn_reg    <= warn_next;
      crc_reg     <= crc_next;
      tx_reg      <= tx_next;
      dir_reg     <= dir_next;
      busy_reg    <= busy_next;
      err_reg     <= err_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    bit_next   = bit_reg;
    byte_next  = byte_reg;
    shift_next = shift_reg;
    pos_next   = pos_reg;
    warn_next  = warn_reg;
    crc_next   = crc_reg;
    dir_next   = dir_reg;
    err_next   = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (iEn && rx_prev_reg && !rx_sync_reg) begin
          state_next = RX;
          bit_next   = '0;
        end
      end
      RX: begin
        if (!iEn) begin
          state_next = IDLE;
        end else if ((bit_reg == 4'd0) ? (cnt_reg == HALF_LAST) : (cnt_reg == BIT_LAST)) begin
          cnt_next = '0;
          if (bit_reg == 4'd0) begin
            if (rx_sync_reg) state_next = IDLE;
            else             bit_next   = 4'd1;
          end else if (bit_reg == 4'd9) begin
            // Stop-bit sample: everything about the command is decided here.
            if (!rx_sync_reg) begin
              state_next = IDLE;
            end else if (shift_reg != CMD_READ) begin
              state_next = IDLE;
              err_next   = 1'b1;
            end else begin
              state_next = TURN;
              pos_next   = iPos_st;
              warn_next  = iWarning;
            end
          end else begin
            shift_next = {rx_sync_reg, shift_reg[7:1]};
            bit_next   = bit_reg + 4'd1;
          end
        end
      end
      TURN: begin
        crc_next = crc_calc;
        if (cnt_reg == TURN_LAST) begin
          state_next = PRE;
          cnt_next   = '0;
          dir_next   = 1'b1;
        end
      end
      PRE: begin
        if (cnt_reg == BIT_LAST) begin
          state_next = TX;
          cnt_next   = '0;
          bit_next   = '0;
          byte_next  = '0;
        end
      end
      TX: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (bit_reg == 4'd9) begin
            if (byte_reg == 3'd4) begin
              state_next = IDLE;
              dir_next   = 1'b0;
              done_next  = 1'b1;
            end else begin
              byte_next = byte_reg + 3'd1;
              bit_next  = '0;
            end
          end else begin
            bit_next = bit_reg + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output bit is derived from the next bit position so oTx is registered.
  always_comb begin
    case (byte_next)
      3'd0:    cur_byte = CMD_READ;
      3'd1:    cur_byte = pos_reg[7:0];
      3'd2:    cur_byte = pos_reg[15:8];
      3'd3:    cur_byte = {warn_reg, 3'b000, pos_reg[19:16]};
      default: cur_byte = crc_reg;
    endcase
    tx_next = 1'b1;
    if (state_next == TX) begin
      if (bit_next == 4'd0)      tx_next = 1'b0;
      else if (bit_next <= 4'd8) tx_next = cur_byte[3'(bit_next - 4'd1)];
    end
    busy_next = (state_next != IDLE);
  end

  assign oTx         = tx_reg;
  assign oDir        = dir_reg;
  assign oBusy       = busy_reg;
  assign oCmd_err    = err_reg;
  assign oFrame_done = done_reg;

endmodule

// File: tb/tb_nikon_enc_emu.sv
// Bench for nikon_enc_emu: a timeline model predicts every output on every
// cycle from the link rules; a line decoder recovers the response bytes.
module tb_nikon_enc_emu;
  localparam int         CPB  = 8;
  localparam int         TURN = 40;
  localparam int         HALF = CPB / 2;
  localparam logic [7:0] CMD  = 8'h1A;
  localparam int         NCYC = 24000;

  logic        iClk, iRst, iEn, iRx, iWarning;
  logic [19:0] iPos_st;
  logic        oTx, oDir, oBusy, oCmd_err, oFrame_done;

  nikon_enc_emu #(.CLKS_PER_BIT(CPB), .TURN_CLKS(TURN), .CMD_READ(CMD)) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iRx(iRx), .iPos_st(iPos_st),
    .iWarning(iWarning), .oTx(oTx), .oDir(oDir), .oBusy(oBusy),
    .oCmd_err(oCmd_err), .oFrame_done(oFrame_done));

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  // expected {tx, dir, busy, cmd_err, frame_done} per cycle
  logic [4:0] exp_out [NCYC];
  logic [7:0] mb [5];
  int busy_end = 0;
  int last_S = 0;
  bit last_resp = 0;
  int total = 0;
  int bad = 0;
  bit tests_done = 0;

  // monitor and decoder keep cumulative counts; tests look at deltas
  int dir_cnt = 0, done_cnt = 0, err_cnt = 0, dir_rise = -1;
  logic dir_prev = 1'b0;
  always @(negedge iClk) begin
    if (oDir === 1'b1 && dir_prev !== 1'b1) dir_rise = cyc;
    if (oDir === 1'b1) dir_cnt++;
    if (oFrame_done === 1'b1) done_cnt++;
    if (oCmd_err === 1'b1) err_cnt++;
    dir_prev = oDir;
  end

  logic [7:0] dec_q [$];
  logic [7:0] dec_byte;
  logic dec_prev = 1'b1;
  always begin
    @(negedge iClk);
    if (oDir === 1'b1 && oTx === 1'b0 && dec_prev) begin
      repeat (HALF) @(negedge iClk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge iClk);
        dec_byte[i] = oTx;
      end
      repeat (CPB) @(negedge iClk);
      dec_q.push_back(dec_byte);
      dec_prev = 1'b1;
    end else begin
      dec_prev = (oTx !== 1'b0);
    end
  end

  function automatic logic [7:0] crc_model(input logic [31:0] msg);
    logic [39:0] r;
    r = {msg, 8'h00};
    for (int i = 39; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  task automatic set_field(input int c, input int idx, input logic v);
    if (c >= 0 && c < NCYC) exp_out[c][idx] = v;
  endtask

  task automatic model_frame(input int n, input logic [7:0] b, input logic stop,
                             input logic en, input logic [19:0] pos, input logic warn);
    int f, s, r, e, base;
    logic bv;
    f = n + 3;
    last_resp = 0;
    if (!en || f <= busy_end) return;
    s = f + HALF + 9 * CPB;
    last_S = s;
    if (!stop || b != CMD) begin
      for (int c = f; c < s; c++) set_field(c, 2, 1'b1);
      if (stop) set_field(s, 1, 1'b1);
      busy_end = s;
      return;
    end
    mb[0] = CMD; mb[1] = pos[7:0]; mb[2] = pos[15:8];
    mb[3] = {warn, 3'b000, pos[19:16]};
    mb[4] = crc_model({mb[0], mb[1], mb[2], mb[3]});
    r = s + TURN;
    e = r + 51 * CPB;
    for (int c = f; c < e; c++) set_field(c, 2, 1'b1);
    for (int c = r; c < e; c++) set_field(c, 3, 1'b1);
    set_field(e, 0, 1'b1);
    for (int fr = 0; fr < 5; fr++)
      for (int k = 0; k < 10; k++) begin
        bv = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : mb[fr][k-1];
        base = r + CPB + (10 * fr + k) * CPB;
        if (!bv) for (int j = 0; j < CPB; j++) set_field(base + j, 4, 1'b0);
      end
    busy_end = e;
    last_resp = 1;
  endtask

  task automatic model_glitch(input int n);
    int f;
    f = n + 3;
    if (!iEn || f <= busy_end) return;
    for (int c = f; c < f + HALF; c++) set_field(c, 2, 1'b1);
    busy_end = f + HALF;
  endtask

  task automatic model_reset(input int r);
    for (int c = r + 1; c < NCYC; c++) exp_out[c] = 5'b10000;
    busy_end = r + 1;
  endtask

  task automatic host_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    model_frame(cyc, b, stop, iEn, iPos_st, iWarning);
    for (int k = 0; k < 10; k++) begin
      iRx = bits[k];
      repeat (CPB) @(negedge iClk);
    end
    iRx = 1'b1;
  endtask

  task automatic glitch();
    model_glitch(cyc);
    iRx = 1'b0;
    repeat (2) @(negedge iClk);
    iRx = 1'b1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge iClk);
  endtask

  task automatic chk_resp(input string name, input int q0);
    logic [7:0] got;
    chk({name, "_count"}, dec_q.size() - q0, 5);
    for (int i = 0; i < 5; i++) begin
      got = 8'hxx;
      if (dec_q.size() > q0 + i) got = dec_q[q0 + i];
      chk(name, {24'h0, got}, {24'h0, mb[i]});
    end
  endtask

  task automatic run_tests();
    int q0, d0, f0, e0, r;
    logic [7:0] nom [5];
    logic [7:0] b;
    logic stop;
    int sel;
    nom[0] = 8'h1A; nom[1] = 8'hDE; nom[2] = 8'hBC; nom[3] = 8'h8A; nom[4] = 8'hF4;
    repeat (3) @(negedge iClk);
    chk("rst_tx", oTx, 1); chk("rst_dir", oDir, 0); chk("rst_busy", oBusy, 0);
    chk("rst_err", oCmd_err, 0); chk("rst_done", oFrame_done, 0);
    iRst = 1'b0;
    repeat (5) @(negedge iClk);

    // nominal read
    iPos_st = 20'hABCDE; iWarning = 1'b1;
    q0 = dec_q.size(); d0 = dir_cnt; f0 = done_cnt;
    host_frame(CMD, 1'b1);
    wait_until(busy_end + 20);
    chk("crc_lit", crc_model(32'h1ADEBC8A), 8'hF4);
    chk("model_b4", mb[4], 8'hF4);
    chk("nom_count", dec_q.size() - q0, 5);
    for (int i = 0; i < 5; i++) chk("nom_byte", (dec_q.size() > q0 + i) ? dec_q[q0 + i] : 8'hxx, nom[i]);
    chk("dir_rise", dir_rise, last_S + 40);
    chk("dir_len", dir_cnt - d0, 408);
    chk("nom_done", done_cnt - f0, 1);

    // position latched at S, changed one cycle later
    iPos_st = 20'h00001; iWarning = 1'b0;
    q0 = dec_q.size();
    host_frame(CMD, 1'b1);
    iPos_st = 20'hFFFFF; iWarning = 1'b1;
    wait_until(busy_end + 20);
    chk("latch_b1", (dec_q.size() > q0 + 1) ? dec_q[q0 + 1] : 8'hxx, 8'h01);
    chk("latch_b2", (dec_q.size() > q0 + 2) ? dec_q[q0 + 2] : 8'hxx, 8'h00);
    chk("latch_b3", (dec_q.size() > q0 + 3) ? dec_q[q0 + 3] : 8'hxx, 8'h00);

    // wrong command
    q0 = dec_q.size(); d0 = dir_cnt; e0 = err_cnt;
    host_frame(8'h55, 1'b1);
    wait_until(busy_end + 20);
    chk("wrong_err", err_cnt - e0, 1);
    chk("wrong_dir", dir_cnt - d0, 0);
    chk("wrong_bytes", dec_q.size() - q0, 0);

    // framing error and glitch, then a normal read
    d0 = dir_cnt; e0 = err_cnt; f0 = done_cnt;
    host_frame(CMD, 1'b0);
    repeat (20) @(negedge iClk);
    glitch();
    repeat (20) @(negedge iClk);
    chk("frm_err", err_cnt - e0, 0);
    chk("frm_done", done_cnt - f0, 0);
    chk("frm_dir", dir_cnt - d0, 0);
    q0 = dec_q.size(); iPos_st = 20'h3C5A9;
    host_frame(CMD, 1'b1);
    wait_until(busy_end + 20);
    chk("frm_next_done", done_cnt - f0, 1);
    chk_resp("frm_next", q0);

    // reset in the middle of B2
    host_frame(CMD, 1'b1);
    wait_until(last_S + TURN + CPB + 20 * CPB + 12);
    r = cyc;
    model_reset(r);
    iRst = 1'b1;
    @(negedge iClk);
    chk("rst_mid_tx", oTx, 1); chk("rst_mid_dir", oDir, 0); chk("rst_mid_busy", oBusy, 0);
    iRst = 1'b0;
    repeat (120) @(negedge iClk);
    q0 = dec_q.size(); iPos_st = 20'h5A0F3; iWarning = 1'b0;
    host_frame(CMD, 1'b1);
    wait_until(busy_end + 20);
    chk_resp("post_rst", q0);

    // disabled responder, then a host frame during TX
    d0 = dir_cnt; iEn = 1'b0;
    host_frame(CMD, 1'b1);
    iEn = 1'b1;
    repeat (20) @(negedge iClk);
    chk("en_dir", dir_cnt - d0, 0);
    q0 = dec_q.size(); iPos_st = 20'h9E217; iWarning = 1'b1;
    host_frame(CMD, 1'b1);
    wait_until(last_S + TURN + CPB + 100);
    host_frame(8'h00, 1'b1);
    wait_until(busy_end + 20);
    chk_resp("overlap", q0);

    // randomized transactions
    for (int it = 0; it < 12; it++) begin
      iPos_st = 20'($urandom); iWarning = 1'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        glitch();
        repeat (10) @(negedge iClk);
      end
      b = (sel == 1) ? 8'($urandom) : CMD;
      stop = (sel == 2) ? 1'b0 : 1'b1;
      q0 = dec_q.size();
      host_frame(b, stop);
      iPos_st = 20'($urandom);
      wait_until(busy_end + $urandom_range(2, 30));
      if (last_resp) chk_resp("rand", q0);
    end
    repeat (10) @(negedge iClk);
  endtask

  initial begin
    for (int c = 0; c < NCYC; c++) exp_out[c] = 5'b10000;
    iRst = 1'b1; iEn = 1'b1; iRx = 1'b1; iPos_st = '0; iWarning = 1'b0;
    fork
      begin
        run_tests();
        tests_done = 1;
      end
      begin
        while (!tests_done) begin
          @(negedge iClk);
          if (cyc >= 1 && cyc < NCYC)
            chk("outputs", {27'h0, oTx, oDir, oBusy, oCmd_err, oFrame_done}, {27'h0, exp_out[cyc]});
        end
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
